// File: rtl/accel_pkg.sv
// Shared accelerator front-end types: host/instruction widths and packer state encoding.
package accel_pkg;

    localparam int unsigned ACC_HOST_W     = 32;
    localparam int unsigned ACC_INSTR_W    = 64;
    localparam int unsigned ACC_FIFO_DEPTH = 4;

    typedef logic [ACC_INSTR_W-1:0] instr_t;

    // Packer phase: waiting for the low word, or holding it for the high word.
    typedef enum logic {
        PK_LOW  = 1'b0,
        PK_HIGH = 1'b1
    } pack_state_e;

endpackage : accel_pkg

// File: rtl/instr_sync_fifo.sv
// Synchronous show-ahead FIFO: head is visible while non-empty, with a sync clear.
module instr_sync_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    // Clear discards any push in the same cycle; a pop is simply absorbed by the clear.
    assign push_ok = push_i && !full_o && !clear_i;
    assign pop_ok  = pop_i && !empty_o && !clear_i;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                wr_d = wr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_d = rd_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

endmodule : instr_sync_fifo

// File: rtl/instr_stream_packer.sv
// Packs pairs of 32-bit host words (low first) into 64-bit instructions and queues them
// towards the accelerator input, honouring its buffer_full backpressure.
module instr_stream_packer
    import accel_pkg::*;
#(
    parameter  int unsigned HOST_W     = ACC_HOST_W,
    parameter  int unsigned INSTR_W    = ACC_INSTR_W,
    parameter  int unsigned FIFO_DEPTH = ACC_FIFO_DEPTH,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [HOST_W-1:0]  host_data,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic               flush,
    input  logic               acc_buffer_full,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [CNT_W-1:0]   fill_level,
    output logic               half_pending
);

    if (INSTR_W != 2 * HOST_W) begin : g_bad_width
        $error("instr_stream_packer: INSTR_W must equal 2*HOST_W");
    end

    pack_state_e        state_q, state_d;
    logic [HOST_W-1:0]  low_q, low_d;
    logic               host_accept;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [INSTR_W-1:0] push_data;

    assign host_ready   = !fifo_full && !flush;
    assign host_accept  = host_valid && host_ready;
    assign push_data    = {host_data, low_q};
    assign half_pending = (state_q == PK_HIGH);
    assign instr_valid  = !fifo_empty;
    assign fifo_pop     = instr_valid && !acc_buffer_full;

    // Pack phase: first word parks in low_q, second word completes and pushes the pair.
    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        fifo_push = 1'b0;
        if (flush) begin
            state_d = PK_LOW;
        end else if (host_accept) begin
            case (state_q)
                PK_LOW: begin
                    low_d   = host_data;
                    state_d = PK_HIGH;
                end
                PK_HIGH: begin
                    fifo_push = 1'b1;
                    state_d   = PK_LOW;
                end
                default: state_d = PK_LOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PK_LOW;
            low_q   <= '0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
        end
    end

    instr_sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (flush),
        .push_i      (fifo_push),
        .push_data_i (push_data),
        .pop_i       (fifo_pop),
        .head_o      (instr_out),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fill_level)
    );

endmodule : instr_stream_packer
